// File: rtl/udp_tx_sched.sv
// UDP transmit burst scheduler.
// Per packet: header request/ack, then a payload read-address stream gated by
// downstream ready, then an inter-packet gap. Length, start address and packet
// count are captured when a burst is accepted, so later input changes cannot
// disturb a burst in flight.
module udp_tx_sched #(
    parameter int AW         = 16,
    parameter int IPG_CYCLES = 12,
    parameter int MAX_LEN    = 2000
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          i_enable,
    input  logic          i_trig,
    input  logic [15:0]   i_pkt_cnt,
    input  logic [15:0]   i_udp_pkt_len,
    input  logic [15:0]   i_udp_start_addr,
    output logic          o_hdr_req,
    input  logic          i_hdr_ack,
    output logic [15:0]   o_pay_len,
    output logic          o_rd_en,
    output logic [AW-1:0] o_rd_addr,
    output logic          o_rd_last,
    input  logic          i_tx_ready,
    output logic          o_busy,
    output logic          o_done,
    output logic          o_err
);

    typedef enum logic [1:0] {IDLE, HDR, PAY, GAP} state_t;

    state_t        state;
    logic [15:0]   pkt_rem;   // packets still to send, including the current one
    logic [15:0]   wcnt;      // payload words left in the current packet
    logic [15:0]   gap_cnt;
    logic [AW-1:0] addr;      // runs contiguously across all packets of a burst
    logic [15:0]   len_clamp;
    logic [16:0]   len_rnd;
    logic [15:0]   words;

    assign len_clamp = (i_udp_pkt_len > 16'(MAX_LEN)) ? 16'(MAX_LEN) : i_udp_pkt_len;
    // o_pay_len doubles as the length shadow; round bytes up to whole words
    assign len_rnd   = {1'b0, o_pay_len} + 17'd3;
    assign words     = {1'b0, len_rnd[16:2]};

    // Payload beats follow downstream ready directly so stalls cost no cycles
    assign o_rd_en   = (state == PAY) && i_tx_ready;
    assign o_rd_last = o_rd_en && (wcnt == 16'd1);
    assign o_rd_addr = addr;
    assign o_busy    = (state != IDLE);

    // Burst sequencing, parameter shadowing and registered handshake/status outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            pkt_rem   <= '0;
            wcnt      <= '0;
            gap_cnt   <= '0;
            addr      <= '0;
            o_pay_len <= '0;
            o_hdr_req <= 1'b0;
            o_done    <= 1'b0;
            o_err     <= 1'b0;
        end else begin
            o_done <= 1'b0;
            o_err  <= 1'b0;
            // A trigger while a burst runs is refused but never disturbs it
            if (i_trig && state != IDLE)
                o_err <= 1'b1;
            case (state)
                IDLE: begin
                    if (i_trig && i_enable) begin
                        if (i_udp_pkt_len == 16'd0) begin
                            o_err <= 1'b1;
                        end else begin
                            o_pay_len <= len_clamp;
                            addr      <= i_udp_start_addr[AW-1:0];
                            pkt_rem   <= (i_pkt_cnt == 16'd0) ? 16'd1 : i_pkt_cnt;
                            o_hdr_req <= 1'b1;
                            state     <= HDR;
                        end
                    end
                end
                HDR: begin
                    if (i_hdr_ack) begin
                        o_hdr_req <= 1'b0;
                        wcnt      <= words;
                        state     <= PAY;
                    end
                end
                PAY: begin
                    if (o_rd_en) begin
                        addr <= addr + 1'b1;
                        wcnt <= wcnt - 16'd1;
                        if (wcnt == 16'd1) begin
                            pkt_rem <= pkt_rem - 16'd1;
                            // Enable is only honoured at packet boundaries
                            if (pkt_rem > 16'd1 && i_enable) begin
                                gap_cnt <= 16'(IPG_CYCLES - 1);
                                state   <= GAP;
                            end else begin
                                o_done <= 1'b1;
                                state  <= IDLE;
                            end
                        end
                    end
                end
                GAP: begin
                    if (!i_enable) begin
                        o_done <= 1'b1;
                        state  <= IDLE;
                    end else if (gap_cnt == 16'd0) begin
                        o_hdr_req <= 1'b1;
                        state     <= HDR;
                    end else begin
                        gap_cnt <= gap_cnt - 16'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_udp_tx_sched.sv
// Bench for udp_tx_sched: vector table of bursts checked through an address
// scoreboard, plus hand sequences for rejected triggers and mid-packet reset.
module tb_udp_tx_sched;

    localparam int AW  = 16;
    localparam int IPG = 12;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          i_enable, i_trig, i_hdr_ack, i_tx_ready;
    logic [15:0]   i_pkt_cnt, i_udp_pkt_len, i_udp_start_addr;
    logic          o_hdr_req, o_rd_en, o_rd_last, o_busy, o_done, o_err;
    logic [15:0]   o_pay_len;
    logic [AW-1:0] o_rd_addr;

    always #5 clk = ~clk;

    udp_tx_sched #(.AW(AW), .IPG_CYCLES(IPG), .MAX_LEN(2000)) dut (
        .clk(clk), .rst_n(rst_n), .i_enable(i_enable), .i_trig(i_trig),
        .i_pkt_cnt(i_pkt_cnt), .i_udp_pkt_len(i_udp_pkt_len),
        .i_udp_start_addr(i_udp_start_addr), .o_hdr_req(o_hdr_req),
        .i_hdr_ack(i_hdr_ack), .o_pay_len(o_pay_len), .o_rd_en(o_rd_en),
        .o_rd_addr(o_rd_addr), .o_rd_last(o_rd_last), .i_tx_ready(i_tx_ready),
        .o_busy(o_busy), .o_done(o_done), .o_err(o_err)
    );

    typedef struct {
        logic [15:0] addr;
        logic        last;
    } beat_t;

    typedef struct {
        logic [15:0] len, cnt, start;
        int          mode;       // 0 ready=1, 1 ready toggles, 2 ready random
        int          trig_at;    // loop cycle of a stray trigger, -1 none
        int          drop_at;    // loop cycle where enable drops, -1 none
        logic [15:0] exp_len;
        int          exp_beats, exp_pkts, exp_err;
    } vec_t;

    beat_t exp_q[$];
    int checks = 0, errors = 0;
    int cyc = 0, n_beats = 0, n_req = 0, n_done = 0, n_err = 0;
    int last_beat_cyc = -1, done_cyc = -1, min_gap = 1000000;
    logic prev_req = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Observe outputs once per cycle, away from the rising edge
    task automatic sample();
        beat_t b;
        cyc++;
        if (rst_n) begin
            if (o_rd_en) begin
                n_beats++;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL beat_unexpected: got addr %0h, none expected", o_rd_addr);
                end else begin
                    b = exp_q.pop_front();
                    if (o_rd_addr !== b.addr || o_rd_last !== b.last) begin
                        errors++;
                        $display("FAIL beat: got addr %0h last %0b expected addr %0h last %0b",
                                 o_rd_addr, o_rd_last, b.addr, b.last);
                    end
                end
                if (o_rd_last) last_beat_cyc = cyc;
            end
            if (o_hdr_req && !prev_req) begin
                n_req++;
                if (last_beat_cyc >= 0 && (cyc - last_beat_cyc - 1) < min_gap)
                    min_gap = cyc - last_beat_cyc - 1;
            end
            if (o_done) begin
                n_done++;
                done_cyc = cyc;
            end
            if (o_err) n_err++;
            prev_req = o_hdr_req;
        end else begin
            prev_req = 1'b0;
        end
    endtask

    task automatic step();
        @(negedge clk);
        sample();
        @(posedge clk);
        #1;
    endtask

    task automatic push_model(input logic [15:0] len, input logic [15:0] start, input int npk);
        int          l, w;
        logic [15:0] a;
        beat_t       b;
        l = (len > 16'd2000) ? 2000 : int'(len);
        w = (l + 3) / 4;
        a = start;
        for (int p = 0; p < npk; p++)
            for (int i = 0; i < w; i++) begin
                b.addr = a;
                b.last = (i == w - 1);
                exp_q.push_back(b);
                a = a + 16'd1;
            end
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        int  b0, r0, d0, e0;
        bit  fin;
        string s;
        b0 = n_beats; r0 = n_req; d0 = n_done; e0 = n_err;
        last_beat_cyc = -1; min_gap = 1000000; fin = 0;
        push_model(v.len, v.start, v.exp_pkts);
        i_enable = 1'b1; i_udp_pkt_len = v.len; i_pkt_cnt = v.cnt; i_udp_start_addr = v.start;
        i_trig = 1'b1;
        step();
        i_trig = 1'b0;
        for (int k = 0; k < 6000; k++) begin
            i_hdr_ack = o_hdr_req;
            case (v.mode)
                0:       i_tx_ready = 1'b1;
                1:       i_tx_ready = (k % 2) == 0;
                default: i_tx_ready = 1'($urandom_range(0, 1));
            endcase
            i_trig = (k == v.trig_at);
            if (k == v.trig_at) begin
                i_udp_pkt_len = 16'h0040; i_udp_start_addr = 16'h5555; i_pkt_cnt = 16'd9;
            end
            if (k == v.drop_at) i_enable = 1'b0;
            step();
            if (n_done != d0) begin fin = 1; break; end
        end
        i_trig = 1'b0; i_hdr_ack = 1'b0; i_enable = 1'b1; i_tx_ready = 1'b1;
        step();
        s = $sformatf("v%0d_", idx);
        chk({s, "timeout"}, 32'(fin), 32'd1);
        chk({s, "pay_len"}, 32'(o_pay_len), 32'(v.exp_len));
        chk({s, "beats"}, 32'(n_beats - b0), 32'(v.exp_beats));
        chk({s, "hdr_reqs"}, 32'(n_req - r0), 32'(v.exp_pkts));
        chk({s, "done_pulses"}, 32'(n_done - d0), 32'd1);
        chk({s, "err_pulses"}, 32'(n_err - e0), 32'(v.exp_err));
        chk({s, "sb_empty"}, 32'(exp_q.size()), 32'd0);
        chk({s, "busy_after"}, 32'(o_busy), 32'd0);
        if (v.drop_at < 0)
            chk({s, "done_latency"}, 32'(done_cyc - last_beat_cyc), 32'd1);
        if (v.exp_pkts > 1)
            chk({s, "ipg_ok"}, 32'(min_gap >= IPG), 32'd1);
        exp_q.delete();
    endtask

    vec_t vecs[9];
    int   e0, d0, b0;

    initial begin
        vecs[0] = '{16'd8,    16'd1, 16'h0010, 0, -1, -1, 16'd8,    2,    1, 0};
        vecs[1] = '{16'd5,    16'd3, 16'hFFFE, 0, -1, -1, 16'd5,    6,    3, 0};
        vecs[2] = '{16'd4000, 16'd1, 16'h0100, 1, -1, -1, 16'd2000, 500,  1, 0};
        vecs[3] = '{16'd1,    16'd0, 16'h1234, 2, -1, -1, 16'd1,    1,    1, 0};
        vecs[4] = '{16'd2001, 16'd2, 16'hFFF0, 2, -1, -1, 16'd2000, 1000, 2, 0};
        vecs[5] = '{16'd16,   16'd2, 16'h0040, 0,  3, -1, 16'd16,   8,    2, 1};
        vecs[6] = '{16'd8,    16'd4, 16'h0020, 0, -1,  1, 16'd8,    2,    1, 0};
        vecs[7] = '{16'd13,   16'd2, 16'h8000, 1, -1, -1, 16'd13,   8,    2, 0};
        vecs[8] = '{16'd6,    16'd3, 16'h0200, 0, -1,  6, 16'd6,    2,    1, 0};

        rst_n = 1'b1; i_enable = 1'b0; i_trig = 1'b0; i_pkt_cnt = '0;
        i_udp_pkt_len = '0; i_udp_start_addr = '0; i_hdr_ack = 1'b0; i_tx_ready = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("reset_ctrl", {o_hdr_req, o_rd_en, o_rd_last, o_busy, o_done, o_err}, 32'd0);
        chk("reset_pay_len", 32'(o_pay_len), 32'd0);
        chk("reset_rd_addr", 32'(o_rd_addr), 32'd0);
        step(); step();
        rst_n = 1'b1;
        step();

        // Zero length: refused with an error pulse, scheduler stays idle
        e0 = n_err;
        i_enable = 1'b1; i_udp_pkt_len = 16'd0; i_pkt_cnt = 16'd1; i_trig = 1'b1;
        step();
        i_trig = 1'b0;
        chk("len0_busy", 32'(o_busy), 32'd0);
        step(); step();
        chk("len0_err", 32'(n_err - e0), 32'd1);

        // Trigger without enable is silently ignored
        e0 = n_err;
        i_enable = 1'b0; i_udp_pkt_len = 16'd8; i_trig = 1'b1;
        step();
        i_trig = 1'b0;
        chk("noen_busy", 32'(o_busy), 32'd0);
        step(); step();
        chk("noen_err", 32'(n_err - e0), 32'd0);
        i_enable = 1'b1;

        for (int i = 0; i < 9; i++) run_vec(i, vecs[i]);

        // Reset during payload: outputs clear immediately, no completion pulse
        push_model(16'd400, 16'h0300, 1);
        i_udp_pkt_len = 16'd400; i_pkt_cnt = 16'd1; i_udp_start_addr = 16'h0300;
        i_tx_ready = 1'b1; i_trig = 1'b1;
        step();
        i_trig = 1'b0;
        b0 = n_beats;
        for (int k = 0; k < 40 && (n_beats - b0) < 10; k++) begin
            i_hdr_ack = o_hdr_req;
            step();
        end
        i_hdr_ack = 1'b0;
        chk("rst_mid_in_pay", 32'(o_rd_en), 32'd1);
        d0 = n_done;
        rst_n = 1'b0;
        #1;
        chk("rst_mid_ctrl", {o_hdr_req, o_rd_en, o_rd_last, o_busy, o_done, o_err}, 32'd0);
        chk("rst_mid_addr", 32'(o_rd_addr), 32'd0);
        chk("rst_mid_len", 32'(o_pay_len), 32'd0);
        exp_q.delete();
        step();
        rst_n = 1'b1;
        b0 = n_beats;
        for (int k = 0; k < 20; k++) step();
        chk("rst_mid_no_done", 32'(n_done - d0), 32'd0);
        chk("rst_mid_no_beats", 32'(n_beats - b0), 32'd0);
        chk("rst_mid_idle", 32'(o_busy), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
